clk_gate_ctrl: RTL and testbench

Clock-gating controller for the buffered clock tree. It gates `mclk` onto a single gated output `gclk` and shares that clock between `NREQ` requesters using a level req/ack handshake. On the first request it runs a counted wake-up before granting. After the last request drops it holds the clock on through an idle hysteresis before shutting it off. It sits between the master clock buffer and the downstream clock-consuming blocks.

---
 rtl/clk_ctrl_pkg.sv | 17 +
 rtl/clk_gate_cell.sv | 21 ++
 rtl/clk_gate_ctrl.sv | 113 +++++++++++
 tb/tb_clk_gate_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the gated-clock controller.
// State encodings and default wake/idle cycle counts.
package clk_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        IDLE = 2'd3
    } state_t;

    localparam int DEF_WAKE_CYC = 4;
    localparam int DEF_IDLE_CYC = 16;

endpackage

// File: rtl/clk_gate_cell.sv
// Glitch-free clock gate: negative-level enable latch plus AND.
// Reset clears the latch so gclk drops immediately.
module clk_gate_cell (
    input  logic mclk,
    input  logic rst,
    input  logic en,
    output logic gclk
);

    logic en_lat;

    always_latch begin
        if (rst)
            en_lat <= 1'b0;
        else if (!mclk)
            en_lat <= en;
    end

    assign gclk = mclk & en_lat;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gating controller: wake-up count, shared level req/ack,
// idle hysteresis before shut-off, and one gate cell on mclk.
module clk_gate_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WAKE_CYC = DEF_WAKE_CYC,
    parameter int IDLE_CYC = DEF_IDLE_CYC,
    parameter int CNT_W    = 8
) (
    input  logic               mclk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic               force_on,
    output logic [NREQ-1:0]    ack,
    output logic               gclk,
    output logic               clk_en,
    output logic [STATE_W-1:0] state
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC - 1);

    if (WAKE_CYC < 1 || WAKE_CYC > CNT_MAX) begin : g_bad_wake
        $error("clk_gate_ctrl: WAKE_CYC out of range");
    end
    if (IDLE_CYC < 1 || IDLE_CYC > CNT_MAX) begin : g_bad_idle
        $error("clk_gate_ctrl: IDLE_CYC out of range");
    end

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             any;
    logic             cnt_zero;

    assign any      = (|req) | force_on;
    assign cnt_zero = (cnt == '0);
    assign state    = st;

    // ack is registered alongside the state: req & (next == ON).
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            st     <= OFF;
            cnt    <= '0;
            clk_en <= 1'b0;
            ack    <= '0;
        end else begin
            unique case (st)
                OFF: begin
                    ack <= '0;
                    if (any) begin
                        st     <= WAKE;
                        cnt    <= WAKE_LD;
                        clk_en <= 1'b1;
                    end else begin
                        clk_en <= 1'b0;
                    end
                end
                WAKE: begin
                    clk_en <= 1'b1;
                    if (cnt_zero) begin
                        st  <= ON;
                        ack <= req;
                    end else begin
                        cnt <= cnt - 1'b1;
                        ack <= '0;
                    end
                end
                ON: begin
                    clk_en <= 1'b1;
                    if (!any) begin
                        st  <= IDLE;
                        cnt <= IDLE_LD;
                        ack <= '0;
                    end else begin
                        ack <= req;
                    end
                end
                IDLE: begin
                    // A request on the expiry edge still rescues the clock.
                    if (any) begin
                        st     <= ON;
                        clk_en <= 1'b1;
                        ack    <= req;
                    end else if (cnt_zero) begin
                        st     <= OFF;
                        clk_en <= 1'b0;
                        ack    <= '0;
                    end else begin
                        cnt    <= cnt - 1'b1;
                        clk_en <= 1'b1;
                        ack    <= '0;
                    end
                end
                default: begin
                    st     <= OFF;
                    cnt    <= '0;
                    clk_en <= 1'b0;
                    ack    <= '0;
                end
            endcase
        end
    end

    clk_gate_cell u_gate (
        .mclk (mclk),
        .rst  (rst),
        .en   (clk_en),
        .gclk (gclk)
    );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl; edge n of mclk is at time 10n-5.
// Inputs change and outputs are sampled 1 unit after an edge.
module tb_clk_gate_ctrl;

    logic       mclk;
    logic       rst;
    logic [3:0] req;
    logic       force_on;
    logic [3:0] ack;
    logic       gclk;
    logic       clk_en;
    logic [1:0] state;

    int compared;
    int mismatched;
    int glitches;
    int first_rise;
    int last_rise;

    clk_gate_ctrl #(
        .NREQ     (4),
        .WAKE_CYC (4),
        .IDLE_CYC (16),
        .CNT_W    (8)
    ) dut (
        .mclk     (mclk),
        .rst      (rst),
        .req      (req),
        .force_on (force_on),
        .ack      (ack),
        .gclk     (gclk),
        .clk_en   (clk_en),
        .state    (state)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    always @(posedge gclk) begin
        if (mclk !== 1'b1)
            glitches++;
        last_rise = int'(($time + 5) / 10);
        if (first_rise == 0)
            first_rise = last_rise;
    end

    always @(negedge gclk) begin
        if (mclk !== 1'b0 && rst !== 1'b1)
            glitches++;
    end

    task automatic at_edge(input int n);
        while ($time < 64'(10 * n - 4))
            #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        glitches   = 0;
        first_rise = 0;
        last_rise  = 0;
        rst        = 1'b1;
        req        = 4'b0000;
        force_on   = 1'b0;

        #3;
        check("rst_state", int'(state), 0);
        check("rst_clk_en", int'(clk_en), 0);
        check("rst_ack", int'(ack), 0);
        check("rst_gclk", int'(gclk), 0);
        #19 rst = 1'b0;

        // cold request sampled at edge 10
        at_edge(9);  req = 4'b0001;
        at_edge(10);
        check("cold_state_wake", int'(state), 1);
        check("cold_clk_en", int'(clk_en), 1);
        check("cold_ack_wake", int'(ack), 0);
        at_edge(11);
        check("cold_first_rise", first_rise, 11);
        at_edge(13);
        check("cold_ack_e13", int'(ack), 0);
        check("cold_state_e13", int'(state), 1);
        at_edge(14);
        check("cold_state_on", int'(state), 2);
        check("cold_ack_on", int'(ack), 1);

        // idle shut-off, drop at edge 20
        at_edge(19); req = 4'b0000;
        at_edge(20);
        check("idle_ack", int'(ack), 0);
        check("idle_state", int'(state), 3);
        at_edge(35);
        check("idle_state_e35", int'(state), 3);
        check("idle_clk_en_e35", int'(clk_en), 1);
        at_edge(36);
        check("idle_state_off", int'(state), 0);
        check("idle_clk_en_off", int'(clk_en), 0);
        check("idle_last_rise", last_rise, 36);
        at_edge(40);
        check("off_no_rise", last_rise, 36);

        // idle rescue on the expiry edge 66 (drop at edge 50)
        req = 4'b0001;
        at_edge(45);
        check("resc_on", int'(state), 2);
        at_edge(49); req = 4'b0000;
        at_edge(65);
        check("resc_state_e65", int'(state), 3);
        req = 4'b0100;
        at_edge(66);
        check("resc_state", int'(state), 2);
        check("resc_ack", int'(ack), 4);
        check("resc_clk_en", int'(clk_en), 1);
        at_edge(67);
        check("resc_clock_runs", last_rise, 67);

        // multi-requester in ON, then drop one, then re-raise
        at_edge(69); req = 4'b0011;
        at_edge(70);
        check("multi_ack_0011", int'(ack), 3);
        req = 4'b0010;
        at_edge(71);
        check("multi_ack_0010", int'(ack), 2);
        check("multi_state", int'(state), 2);
        req = 4'b0011;
        at_edge(72);
        check("multi_reraise", int'(ack), 3);
        check("multi_clock_runs", last_rise, 72);
        req = 4'b0000;
        at_edge(89);
        check("multi_off", int'(state), 0);

        // force_on alone from OFF
        at_edge(90); force_on = 1'b1;
        at_edge(94);
        check("force_wake", int'(state), 1);
        at_edge(95);
        check("force_on_state", int'(state), 2);
        check("force_ack", int'(ack), 0);
        for (int e = 96; e <= 130; e++) begin
            at_edge(e);
            check("force_hold_on", int'(state), 2);
        end
        force_on = 1'b0;
        at_edge(131);
        check("force_rel_idle", int'(state), 3);
        at_edge(147);
        check("force_rel_off", int'(state), 0);

        // reset two cycles into WAKE (WAKE from edge 149)
        at_edge(148); req = 4'b0001;
        at_edge(149);
        check("rw_wake", int'(state), 1);
        at_edge(150);
        #1;
        check("rw_gclk_high", int'(gclk), 1);
        rst = 1'b1;
        #1;
        check("rw_gclk_low", int'(gclk), 0);
        check("rw_clk_en", int'(clk_en), 0);
        check("rw_ack", int'(ack), 0);
        check("rw_state", int'(state), 0);
        at_edge(151);
        check("rw_hold_off", int'(state), 0);
        #7 rst = 1'b0;
        at_edge(152);
        check("rw_restart_wake", int'(state), 1);
        at_edge(155);
        check("rw_still_wake", int'(state), 1);
        at_edge(156);
        check("rw_on", int'(state), 2);
        check("rw_ack_on", int'(ack), 1);

        check("no_glitch", glitches, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
